// File: rtl/ymux_pkg.sv
// Shared constants for the registered N:1 mux: state encoding, defaults and select width.
package ymux_pkg;

   localparam int YMUX_WIDTH_DEF = 64;
   localparam int YMUX_N_DEF     = 4;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // At least one select bit, even for degenerate channel counts.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ymux_skid.sv
// Two-entry skid buffer: main register drives the output, skid register absorbs one
// extra word so in_ready depends only on registered state.
module ymux_skid
   import ymux_pkg::*;
#(
   parameter int WIDTH = YMUX_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] main_reg, main_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             accept, emit;

   assign in_ready  = (state_reg != ST_TWO);
   assign out_valid = (state_reg != ST_EMPTY);
   assign out_data  = main_reg;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_ONE;
               main_next  = in_data;
            end
         end
         ST_ONE: begin
            if (accept && emit) begin
               main_next = in_data;
            end else if (accept) begin
               state_next = ST_TWO;
               skid_next  = in_data;
            end else if (emit) begin
               state_next = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // Skid word moves up; no new word can arrive while full.
            if (emit) begin
               state_next = ST_ONE;
               main_next  = skid_reg;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
         main_reg  <= '0;
         skid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
      end
   end

endmodule

// File: rtl/ymux_n_pipe.sv
// Registered N:1 mux with valid/ready handshake; out-of-range selects yield zero.
// Optional sticky out-of-range flag sel_err under YMUX_SEL_CHECK_EN.
module ymux_n_pipe
   import ymux_pkg::*;
#(
   parameter  int WIDTH = YMUX_WIDTH_DEF,
   parameter  int N     = YMUX_N_DEF,
   localparam int SELW  = sel_width(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]    in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready
`ifdef YMUX_SEL_CHECK_EN
   ,
   output logic               sel_err
`endif
);

   logic [WIDTH-1:0] chan [N];
   logic [WIDTH-1:0] sel_data;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_chan
         assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // No channel matches an out-of-range select, so the default zero falls through.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (in_sel == SELW'(k)) begin
            sel_data = chan[k];
         end
      end
   end

   ymux_skid #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .in_data  (sel_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

`ifdef YMUX_SEL_CHECK_EN
   logic sel_err_reg;
   logic sel_oor;

   assign sel_oor = ({1'b0, in_sel} >= (SELW+1)'(N));
   assign sel_err = sel_err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err_reg <= 1'b0;
      end else if (in_valid && in_ready && sel_oor) begin
         sel_err_reg <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ymux_n_pipe.sv
// Bench for ymux_n_pipe: N=4 instance checked against a queue model, N=3 instance
// exercising out-of-range selects (and sel_err when YMUX_SEL_CHECK_EN is defined).
module tb_ymux_n_pipe;

   localparam int W = 64;

   logic            clk = 1'b0;
   logic            reset;

   logic [W-1:0]    ch [4];
   logic [4*W-1:0]  in_data;
   logic [1:0]      in_sel;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;

   logic [W-1:0]    d3_ch [3];
   logic [3*W-1:0]  d3_in_data;
   logic [1:0]      d3_sel;
   logic            d3_valid;
   logic            d3_in_ready;
   logic [W-1:0]    d3_out_data;
   logic            d3_out_valid;
   logic            d3_out_ready;
`ifdef YMUX_SEL_CHECK_EN
   logic            d3_sel_err;
`endif

   logic [W-1:0]    q [$];
   int              checks = 0;
   int              errors = 0;
   int              n_out  = 0;

   always #5 clk = ~clk;

   assign in_data    = {ch[3], ch[2], ch[1], ch[0]};
   assign d3_in_data = {d3_ch[2], d3_ch[1], d3_ch[0]};

   ymux_n_pipe #(.WIDTH(W), .N(4)) dut4 (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef YMUX_SEL_CHECK_EN
      ,
      .sel_err  ()
`endif
   );

   ymux_n_pipe #(.WIDTH(W), .N(3)) dut3 (
      .clk      (clk),
      .reset    (reset),
      .in_data  (d3_in_data),
      .in_sel   (d3_sel),
      .in_valid (d3_valid),
      .in_ready (d3_in_ready),
      .out_data (d3_out_data),
      .out_valid(d3_out_valid),
      .out_ready(d3_out_ready)
`ifdef YMUX_SEL_CHECK_EN
      ,
      .sel_err  (d3_sel_err)
`endif
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: model the handshake on dut4 from the driven inputs, then compare.
   task automatic cycle();
      logic       acc, emt, rst_now;
      logic [W-1:0] cap;
      rst_now = reset;
      acc     = in_valid && (q.size() < 2);
      emt     = (q.size() > 0) && out_ready;
      cap     = ch[in_sel];
      @(posedge clk);
      if (rst_now) begin
         q.delete();
      end else begin
         if (emt) begin
            n_out++;
            $display("out #%0d data=%h", n_out, q[0]);
            void'(q.pop_front());
         end
         if (acc) q.push_back(cap);
      end
      #1;
      chk("out_valid", W'(out_valid), W'(q.size() > 0));
      chk("in_ready", W'(in_ready), W'(q.size() < 2));
      if (q.size() > 0) chk("out_data", out_data, q[0]);
      if (rst_now) chk("out_data_rst", out_data, '0);
   endtask

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_sel       = 2'd0;
      out_ready    = 1'b1;
      d3_valid     = 1'b0;
      d3_sel       = 2'd0;
      d3_out_ready = 1'b1;
      ch[0] = 64'h1111_1111_1111_1111;
      ch[1] = 64'h2222_2222_2222_2222;
      ch[2] = 64'h3333_3333_3333_3333;
      ch[3] = 64'h4444_4444_4444_4444;
      d3_ch[0] = 64'hDEAD_0000_0000_0000;
      d3_ch[1] = 64'hDEAD_BEEF_0000_0001;
      d3_ch[2] = 64'hDEAD_0000_0000_0002;

      // Reset state
      cycle();
      cycle();
      chk("d3_out_valid_rst", W'(d3_out_valid), '0);
      chk("d3_in_ready_rst", W'(d3_in_ready), W'(1'b1));
`ifdef YMUX_SEL_CHECK_EN
      chk("sel_err_rst", W'(d3_sel_err), '0);
`endif
      reset = 1'b0;

      // Single word, sel=2
      in_sel = 2'd2; in_valid = 1'b1;
      cycle();
      chk("single_data", out_data, 64'h3333_3333_3333_3333);
      in_valid = 1'b0;
      cycle();

      // Back-to-back streaming, 16 words, no bubbles
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_sel   = 2'($urandom_range(0, 3));
         cycle();
      end
      in_valid = 1'b0;
      cycle();

      // Backpressure: sels 0, 1, 3 with out_ready low
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd0; cycle();
      in_sel = 2'd1; cycle();
      in_sel = 2'd3; cycle();
      cycle();
      out_ready = 1'b1;
      cycle();
      chk("bp_first", out_data, 64'h2222_2222_2222_2222);
      cycle();
      chk("bp_third", out_data, 64'h4444_4444_4444_4444);
      in_valid = 1'b0;
      cycle();

      // Out-of-range select on N=3
      d3_valid = 1'b1; d3_sel = 2'd2;
      cycle();
      chk("d3_in_range", d3_out_data, d3_ch[2]);
`ifdef YMUX_SEL_CHECK_EN
      chk("sel_err_in_range", W'(d3_sel_err), '0);
`endif
      d3_sel = 2'd3;
      cycle();
      chk("d3_oor_valid", W'(d3_out_valid), W'(1'b1));
      chk("d3_oor_data", d3_out_data, '0);
`ifdef YMUX_SEL_CHECK_EN
      chk("sel_err_set", W'(d3_sel_err), W'(1'b1));
`endif
      d3_sel = 2'd1;
      cycle();
      chk("d3_after_oor", d3_out_data, d3_ch[1]);
      d3_valid = 1'b0;
      cycle();
      chk("d3_drained", W'(d3_out_valid), '0);
`ifdef YMUX_SEL_CHECK_EN
      chk("sel_err_sticky", W'(d3_sel_err), W'(1'b1));
`endif

      // Reset while holding two words
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd1; cycle();
      in_sel = 2'd2; cycle();
      in_valid = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
`ifdef YMUX_SEL_CHECK_EN
      chk("sel_err_cleared", W'(d3_sel_err), '0);
`endif
      chk("d3_out_valid_mid_rst", W'(d3_out_valid), '0);
      out_ready = 1'b1;
      cycle();
      cycle();

      // Random valid/ready traffic against the queue model
      for (int i = 0; i < 1000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) ch[$urandom_range(0, 3)] = {$urandom, $urandom};
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("final_empty", W'(q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
